// File: rtl/p2_pool_engine.sv
// p2_pool_engine: 2x2 max-pool of an 8x8 conv2 map into a 4x4 pool2 map.
// Six-state window walk: four reads, a final compare, then one write.
module p2_pool_engine #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [5:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, RD0, RD1, RD2, RD3, CMP, WR, DONE
  } state_t;

  state_t state;

  // win = {prow, pcol}; doubles as the pool2 write address
  logic [3:0] win;
  logic [3:0] win_nx;
  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W-1:0] nmax;

  assign win_nx = win + 4'd1;
  assign din    = $signed(rd_data);
  // strict compare: ties keep the earlier element
  assign nmax   = (din > max_q) ? din : max_q;

  // window FSM with registered memory-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      win     <= '0;
      max_q   <= '0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RD0;
            win     <= '0;
            rd_addr <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        RD0: begin
          state   <= RD1;
          rd_addr <= {win[3:2], 1'b0, win[1:0], 1'b1};
        end
        RD1: begin
          state   <= RD2;
          max_q   <= din;
          rd_addr <= {win[3:2], 1'b1, win[1:0], 1'b0};
        end
        RD2: begin
          state   <= RD3;
          max_q   <= nmax;
          rd_addr <= {win[3:2], 1'b1, win[1:0], 1'b1};
        end
        RD3: begin
          state <= CMP;
          max_q <= nmax;
        end
        CMP: begin
          state   <= WR;
          max_q   <= nmax;
          wr_en   <= 1'b1;
          wr_addr <= win;
          wr_data <= nmax;
        end
        WR: begin
          if (win == 4'hF) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state   <= RD0;
            win     <= win_nx;
            rd_addr <= {win_nx[3:2], 1'b0, win_nx[1:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2_pool_engine.sv
// tb_p2_pool_engine: directed table-driven bench for p2_pool_engine.
// Memory model answers one cycle after the address.
module tb_p2_pool_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;

  p2_pool_engine #(.DATA_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  typedef struct {
    int run;
    int addr;
    int data;
    int cyc;
  } vec_t;

  logic [15:0] mem [64];
  vec_t tbl [48];
  wr_t  wq [$];
  int   cyc = 0;
  int   s0 = 0;
  int   done_abs = 0;
  int   mon_bad = 0;
  logic prev_wr = 1'b0;
  logic prev_done = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always @(posedge clk) rd_data <= mem[rd_addr];
  always @(posedge clk) cyc <= cyc + 1;

  // passive monitor: write log, done rise, protocol rules
  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back('{int'(wr_addr), int'($signed(wr_data)), cyc});
      if (prev_wr) mon_bad = mon_bad + 1;
    end
    if (busy && done) mon_bad = mon_bad + 1;
    if (done && !prev_done) done_abs = cyc;
    prev_wr   = wr_en;
    prev_done = done;
  end

  task automatic load_map(input int id);
    for (int i = 0; i < 64; i++) begin
      unique case (id)
        0: mem[i] = 16'(i);
        1: mem[i] = 16'(-5);
        default: mem[i] = 16'(-100);
      endcase
    end
    if (id == 1) begin
      mem[18] = 16'(-7);
      mem[19] = 16'(-3);
      mem[26] = 16'(-9);
      mem[27] = 16'(-4);
    end
    if (id == 2) begin
      mem[4]  = 16'(10);
      mem[5]  = 16'(10);
      mem[12] = 16'(10);
      mem[13] = 16'(10);
      mem[34] = 16'(7);
      mem[35] = 16'(20);
      mem[42] = 16'(20);
      mem[43] = 16'(3);
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    nvec = nvec + 1;
    if (act != req) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic run_map(input int id, input int busy_pulse);
    int b;
    int n;
    int got;
    load_map(id);
    b = wq.size();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    s0 = cyc;
    chk("start_accept", {busy, done, wr_en, 1'b0},
        {1'b1, 1'b0, 1'b0, 1'b0});
    chk("start_rd_addr", int'(rd_addr), 0);
    if (busy_pulse > 1) begin
      repeat (busy_pulse - 1) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_abs > s0) begin
        got = 1;
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_timeout", got, 1);
    chk("done_cycle", done_abs - s0 + 1, 97);
    chk("end_state", {busy, done, wr_en}, {1'b0, 1'b1, 1'b0});
    n = wq.size() - b;
    chk("write_count", n, 16);
    for (int k = 0; k < 16 && k < n; k++) begin
      vec_t v;
      wr_t  w;
      v = tbl[id * 16 + k];
      w = wq[b + k];
      nvec = nvec + 1;
      if (w.addr != v.addr || w.data != v.data ||
          w.cyc - s0 + 1 != v.cyc) begin
        nerr = nerr + 1;
        $display("FAIL run%0d wr%0d: got a=%0d d=%0d c=%0d, want a=%0d d=%0d c=%0d",
                 id, k, w.addr, w.data, w.cyc - s0 + 1,
                 v.addr, v.data, v.cyc);
      end
    end
  endtask

  initial begin
    int ramp_exp [16];
    int n;
    int got;
    ramp_exp = '{9, 11, 13, 15, 25, 27, 29, 31,
                 41, 43, 45, 47, 57, 59, 61, 63};
    for (int i = 0; i < 16; i++) begin
      tbl[i]      = '{0, i, ramp_exp[i], 6 + 6 * i};
      tbl[16 + i] = '{1, i, (i == 5) ? -3 : -5, 6 + 6 * i};
      tbl[32 + i] = '{2, i, (i == 2) ? 10 : ((i == 9) ? 20 : -100),
                      6 + 6 * i};
    end
    load_map(0);
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rd_addr, wr_en, wr_addr, busy, done}, 0);
    chk("reset_wr_data", int'(wr_data), 0);
    reset = 1'b0;
    n = wq.size();
    repeat (10) @(posedge clk);
    #1;
    chk("idle_hold", {busy, done, 4'(wq.size() - n)}, 0);

    run_map(0, 0);
    run_map(0, 0);
    run_map(1, 0);
    run_map(2, 0);
    run_map(0, 40);

    load_map(0);
    n = wq.size();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wq.size() >= n + 5) begin
        got = 1;
        break;
      end
    end
    chk("fifth_write_seen", got, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun_reset_outputs", {rd_addr, wr_en, wr_addr, busy, done}, 0);
    chk("midrun_reset_wr_data", int'(wr_data), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    n = wq.size();
    repeat (20) @(posedge clk);
    #1;
    chk("no_write_after_reset", wq.size() - n, 0);
    chk("idle_after_reset", {busy, done}, 0);

    run_map(0, 0);

    chk("protocol_monitor", mon_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
